system_led_blink_pio: RTL and testbench

Parametrised Avalon-MM output port for board LEDs. Holds a WIDTH-bit output register with atomic set/clear access. Adds a per-bit blink mask driven by a programmable half-period timebase, so firmware can flash alarm indicators without servicing a timer interrupt. Sits on the system interconnect as a zero-wait-state slave; `out_port` drives the LED pins.

---
 rtl/system_led_pio_pkg.sv | 15 +
 rtl/system_led_blink_timer.sv | 30 +++
 rtl/system_led_blink_pio.sv | 77 +++++++
 tb/tb_system_led_blink_pio.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/system_led_pio_pkg.sv
// Shared constants for the blinking LED PIO slave.
// Register addresses on the 3-bit Avalon-MM address bus.
package system_led_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd6;

endpackage

// File: rtl/system_led_blink_timer.sv
// Half-period timebase: toggles phase every period+1 cycles.
// restart forces cnt=0 and phase=1 on the next edge.
module system_led_blink_timer #(
    parameter int PERIOD_W = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/system_led_blink_pio.sv
// Avalon-MM LED output port with set/clear access and per-bit blink.
// Zero-wait-state slave; readdata is a purely combinational decode.
module system_led_blink_pio
    import system_led_pio_pkg::*;
#(
    parameter int                  WIDTH        = 10,
    parameter int                  PERIOD_W     = 26,
    parameter logic [WIDTH-1:0]    DATA_RESET   = '0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(24999999)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    mask;
    logic [PERIOD_W-1:0] period;
    logic                phase;
    logic                wr;
    logic                restart;
    logic [WIDTH-1:0]    wd;
    logic                unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign restart   = wr && (address == ADDR_PERIOD);
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data   <= DATA_RESET;
            mask   <= '0;
            period <= PERIOD_RESET;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data   <= wd;
                ADDR_MASK:   mask   <= wd;
                ADDR_PERIOD: period <= writedata[PERIOD_W-1:0];
                ADDR_SET:    data   <= data | wd;
                ADDR_CLEAR:  data   <= data & ~wd;
                default:     ;
            endcase
        end
    end

    system_led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .period  (period),
        .phase   (phase)
    );

    // Masked bits are gated by phase; unmasked bits pass DATA straight through.
    assign out_port = data & (~mask | {WIDTH{phase}});

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]    = data;
            ADDR_OUT:    readdata[WIDTH-1:0]    = out_port;
            ADDR_MASK:   readdata[WIDTH-1:0]    = mask;
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
            ADDR_STATUS: readdata[0]            = phase;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_system_led_blink_pio.sv
// Scoreboard bench: two instances (default and 32-bit) on a shared bus.
module tb_system_led_blink_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] rd0, rd1;
    logic [9:0]  out0;
    logic [31:0] out1;

    always #5 clk = ~clk;

    system_led_blink_pio u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0), .out_port(out0)
    );

    system_led_blink_pio #(
        .WIDTH(32), .PERIOD_W(4),
        .DATA_RESET(32'h8000_0001), .PERIOD_RESET(4'd15)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .out_port(out1)
    );

    typedef struct packed {
        logic [31:0] o0, r0, o1, r1;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;

    logic [31:0] md[2], mm[2], mp[2];
    logic [31:0] wm[2] = '{32'h0000_03FF, 32'hFFFF_FFFF};
    logic [31:0] pm[2] = '{32'h03FF_FFFF, 32'h0000_000F};
    logic [31:0] dr[2] = '{32'h0, 32'h8000_0001};
    logic [31:0] pr[2] = '{32'd24999999, 32'd15};
    longint      c;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Phase from edges elapsed since the last restart.
    function automatic logic ph(input int k);
        return ((c / (longint'(mp[k]) + 1)) % 2) == 0;
    endfunction

    function automatic logic [31:0] eout(input int k);
        return md[k] & (~mm[k] | {32{ph(k)}}) & wm[k];
    endfunction

    function automatic logic [31:0] erd(input int k, input logic [2:0] a);
        case (a)
            3'd0:    return md[k];
            3'd1:    return eout(k);
            3'd2:    return mm[k];
            3'd3:    return mp[k];
            3'd6:    return {31'b0, ph(k)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            md[k] = dr[k];
            mm[k] = '0;
            mp[k] = pr[k];
        end
        c = 0;
    endtask

    task automatic cyc(input logic [2:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd);
        exp_t e;
        logic wr;
        @(negedge clk);
        reset_n    = 1'b1;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        wr = cs && !wn;
        for (int k = 0; k < 2; k++) begin
            if (wr) begin
                case (a)
                    3'd0: md[k] = wd & wm[k];
                    3'd2: mm[k] = wd & wm[k];
                    3'd3: mp[k] = wd & pm[k];
                    3'd4: md[k] = md[k] | (wd & wm[k]);
                    3'd5: md[k] = md[k] & ~(wd & wm[k]);
                    default: ;
                endcase
            end
        end
        c = (wr && a == 3'd3) ? 0 : c + 1;
        e.o0 = eout(0);
        e.r0 = erd(0, a);
        e.o1 = eout(1);
        e.r1 = erd(1, a);
        q.push_back(e);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        cyc(a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(a, 1'b1, 1'b1, $urandom);
    endtask

    // Reset with a write strobe held active: nothing may be written.
    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = $urandom;
        model_reset();
        address = 3'd6;
        #1;
        chk("rst_out0", {22'b0, out0}, dr[0]);
        chk("rst_out1", out1, dr[1]);
        chk("rst_stat0", rd0, 32'h1);
        chk("rst_stat1", rd1, 32'h1);
        address = 3'd3;
        #1;
        chk("rst_per0", rd0, pr[0]);
        chk("rst_per1", rd1, pr[1]);
        address = 3'd2;
        #1;
        chk("rst_mask0", rd0, 32'h0);
        chk("rst_mask1", rd1, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && q.size() > 0) begin
                e = q.pop_front();
                chk("out0", {22'b0, out0}, e.o0);
                chk("rd0", rd0, e.r0);
                chk("out1", out1, e.o1);
                chk("rd1", rd1, e.r1);
            end
        end
    end

    initial begin : stim
        logic [2:0]  a;
        logic [31:0] wd;
        do_reset();
        rd_reg(3'd6, 40);
        // set/clear, including bit 31 on the wide instance
        wr_reg(3'd0, 32'h0000_00F0);
        wr_reg(3'd4, 32'h8000_0003);
        rd_reg(3'd0, 1);
        wr_reg(3'd5, 32'h8000_0030);
        rd_reg(3'd0, 1);
        rd_reg(3'd1, 1);
        // blink bit 0
        wr_reg(3'd3, 32'd3);
        wr_reg(3'd0, 32'h0000_03FF);
        wr_reg(3'd2, 32'h0000_0001);
        rd_reg(3'd1, 16);
        // restart mid-count, then period 0
        wr_reg(3'd3, 32'd3);
        rd_reg(3'd6, 2);
        wr_reg(3'd3, 32'd5);
        rd_reg(3'd6, 14);
        wr_reg(3'd3, 32'd5);
        rd_reg(3'd6, 3);
        wr_reg(3'd3, 32'd0);
        rd_reg(3'd6, 6);
        // width truncation and ignored addresses
        wr_reg(3'd0, 32'hFFFF_FFFF);
        rd_reg(3'd0, 1);
        wr_reg(3'd1, 32'h0);
        wr_reg(3'd6, 32'h0);
        wr_reg(3'd7, 32'h0);
        rd_reg(3'd0, 1);
        rd_reg(3'd4, 1);
        rd_reg(3'd5, 1);
        rd_reg(3'd7, 1);
        // reset mid-operation, then watch the reset timebase
        wr_reg(3'd2, 32'hFFFF_FFFF);
        rd_reg(3'd1, 3);
        do_reset();
        wr_reg(3'd2, 32'h8000_0000);
        rd_reg(3'd1, 70);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd3 && $urandom_range(0, 7) != 0)
                wd = $urandom_range(0, 9);
            if ($urandom_range(0, 499) == 0)
                do_reset();
            cyc(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                wd);
        end
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
